seq_digit_detector: RTL and testbench

SEQ_DIGIT_DETECTOR -- requirements
Module: seq_digit_detector

---
 rtl/seq_digit_detector.sv | 129 ++++++++++++
 tb/tb_seq_digit_detector.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_digit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_digit_detector
//  Purpose  : Mealy detector for a SEQ_LEN-digit PATTERN with KMP fallback,
//             running window sum, odd flag and saturating match counter.
//             Optional macro SEQ_OVERLAP_EN enables overlapping detection.
//  Revision : 1.0  initial release
// ============================================================================
module seq_digit_detector #(
    parameter int                          DIGIT_W = 4,
    parameter int                          SEQ_LEN = 4,
    parameter logic [SEQ_LEN*DIGIT_W-1:0]  PATTERN = 16'h0025
) (
    input  logic                                     CLK,
    input  logic                                     RST_n,
    input  logic                                     clr,
    input  logic                                     din_valid,
    input  logic [DIGIT_W-1:0]                       dataIn,
    output logic                                     match,
    output logic                                     odd,
    output logic [DIGIT_W+$clog2(SEQ_LEN+1)-1:0]     sum,
    output logic [7:0]                               match_cnt
);

    localparam int                 IDX_W      = $clog2(SEQ_LEN);
    localparam int                 SUM_W      = DIGIT_W + $clog2(SEQ_LEN + 1);
    localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(SEQ_LEN - 1);

    // Digit k of the pattern, k = 0 being the first digit expected.
    function automatic logic [DIGIT_W-1:0] pat_digit(input int k);
        return PATTERN[(SEQ_LEN-1-k)*DIGIT_W +: DIGIT_W];
    endfunction

    // True when the last len-1 digits of prefix(i) equal prefix(len-1).
    function automatic logic border_ok(input int i, input int len);
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < len - 1; j++) begin
            if (pat_digit(i + 1 - len + j) != pat_digit(j)) ok = 1'b0;
        end
        return ok;
    endfunction

`ifdef SEQ_OVERLAP_EN
    function automatic int overlap_len();
        int  best;
        logic ok;
        best = 0;
        for (int len = 1; len < SEQ_LEN; len++) begin
            ok = 1'b1;
            for (int j = 0; j < len; j++) begin
                if (pat_digit(SEQ_LEN - len + j) != pat_digit(j)) ok = 1'b0;
            end
            if (ok) best = len;
        end
        return best;
    endfunction

    localparam logic [IDX_W-1:0] C_RESTART = IDX_W'(overlap_len());
`else
    localparam logic [IDX_W-1:0] C_RESTART = '0;
`endif

    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [IDX_W-1:0]   w_fallback;
    logic [DIGIT_W-1:0] r_buf [SEQ_LEN];
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   w_sum_next;
    logic [7:0]         r_cnt;
    logic               w_accept;
    logic               w_match;

    assign w_accept = din_valid & ~clr;
    assign w_match  = w_accept && (r_idx == C_LAST_IDX)
                      && (dataIn == pat_digit(SEQ_LEN - 1));

    // Oldest digit leaves the window as the new one enters.
    assign w_sum_next = r_sum - SUM_W'(r_buf[SEQ_LEN-1]) + SUM_W'(dataIn);

    // Longest prefix that is a suffix of (matched prefix + dataIn); ascending
    // len means the last hit wins, i.e. the longest one.
    always_comb begin
        w_fallback = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            for (int len = 1; (len <= i + 1) && (len < SEQ_LEN); len++) begin
                if ((r_idx == IDX_W'(i)) && border_ok(i, len)
                    && (dataIn == pat_digit(len - 1))) begin
                    w_fallback = IDX_W'(len);
                end
            end
        end
    end

    always_comb begin
        w_idx_next = r_idx;
        if (w_accept) begin
            w_idx_next = w_match ? C_RESTART : w_fallback;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_idx <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            for (int i = 0; i < SEQ_LEN; i++) r_buf[i] <= '0;
        end else if (clr) begin
            r_idx <= '0;
            r_sum <= '0;
            r_cnt <= '0;
            for (int i = 0; i < SEQ_LEN; i++) r_buf[i] <= '0;
        end else if (din_valid) begin
            r_idx    <= w_idx_next;
            r_sum    <= w_sum_next;
            r_buf[0] <= dataIn;
            for (int i = 1; i < SEQ_LEN; i++) r_buf[i] <= r_buf[i-1];
            if (w_match && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign match     = w_match;
    assign odd       = w_accept & w_sum_next[0];
    assign sum       = r_sum;
    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_digit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_digit_detector
//  Purpose  : Randomised + directed bench for two detector instances
//             (patterns 0,0,2,5 and 1,2,1,2) against a window-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_digit_detector;

    localparam int SL = 4;

`ifdef SEQ_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_n = 1'b1;
    logic       clr = 1'b0;
    logic       din_valid = 1'b0;
    logic [3:0] dataIn = 4'd0;
    logic       match_a, odd_a, match_b, odd_b;
    logic [6:0] sum_a, sum_b;
    logic [7:0] cnt_a, cnt_b;

    always #5 CLK = ~CLK;

    seq_digit_detector #(.DIGIT_W(4), .SEQ_LEN(4), .PATTERN(16'h0025)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .clr(clr), .din_valid(din_valid),
        .dataIn(dataIn), .match(match_a), .odd(odd_a), .sum(sum_a),
        .match_cnt(cnt_a));

    seq_digit_detector #(.DIGIT_W(4), .SEQ_LEN(4), .PATTERN(16'h1212)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .clr(clr), .din_valid(din_valid),
        .dataIn(dataIn), .match(match_b), .odd(odd_b), .sum(sum_b),
        .match_cnt(cnt_b));

    // Model: last SL accepted digits (oldest at [0]), digits since the last
    // detection boundary, and match count.
    int pat   [2][SL] = '{'{0, 0, 2, 5}, '{1, 2, 1, 2}};
    int win   [2][SL];
    int avail [2];
    int cnt   [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int m_sum(input int u);
        int s = 0;
        for (int k = 0; k < SL; k++) s += win[u][k];
        return s;
    endfunction

    function automatic bit m_match(input int u, input int d);
        bit ok = (avail[u] >= SL - 1) && (d == pat[u][SL-1]);
        for (int k = 0; k < SL - 1; k++) if (win[u][k+1] != pat[u][k]) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit m_odd(input int u, input int d);
        return 1'((m_sum(u) - win[u][0] + d) & 1);
    endfunction

    task automatic m_clear();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < SL; k++) win[u][k] = 0;
            avail[u] = 0;
            cnt[u]   = 0;
        end
    endtask

    task automatic m_accept(input int d);
        for (int u = 0; u < 2; u++) begin
            bit m = m_match(u, d);
            for (int k = 0; k < SL - 1; k++) win[u][k] = win[u][k+1];
            win[u][SL-1] = d;
            avail[u]++;
            if (m) begin
                if (cnt[u] < 255) cnt[u]++;
                if (!OVL) avail[u] = 0;
            end
        end
    endtask

    // One clock cycle: drive, check Mealy and registered outputs mid-cycle,
    // then advance the model at the edge.
    task automatic cycle(input bit v, input bit c, input int d);
        bit acc = v && !c;
        din_valid = v;
        clr       = c;
        dataIn    = 4'(d);
        @(negedge CLK);
        check("match_a", int'(match_a), acc ? int'(m_match(0, d)) : 0);
        check("odd_a",   int'(odd_a),   acc ? int'(m_odd(0, d))   : 0);
        check("match_b", int'(match_b), acc ? int'(m_match(1, d)) : 0);
        check("odd_b",   int'(odd_b),   acc ? int'(m_odd(1, d))   : 0);
        check("sum_a",   int'(sum_a),   m_sum(0));
        check("sum_b",   int'(sum_b),   m_sum(1));
        check("cnt_a",   int'(cnt_a),   cnt[0]);
        check("cnt_b",   int'(cnt_b),   cnt[1]);
        @(posedge CLK);
        if (c) m_clear();
        else if (v) m_accept(d);
        #1;
    endtask

    task automatic feed(input int d0, input int d1, input int d2, input int d3);
        cycle(1'b1, 1'b0, d0);
        cycle(1'b1, 1'b0, d1);
        cycle(1'b1, 1'b0, d2);
        cycle(1'b1, 1'b0, d3);
    endtask

    initial begin
        m_clear();
        #1 RST_n = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_match_a", int'(match_a), 0);
        check("rst_odd_a",   int'(odd_a),   0);
        check("rst_sum_a",   int'(sum_a),   0);
        check("rst_cnt_a",   int'(cnt_a),   0);
        check("rst_cnt_b",   int'(cnt_b),   0);
        #2 RST_n = 1'b1;

        // 0,0,2,5 straight after reset release
        feed(0, 0, 2, 5);
        check("s31_sum", int'(sum_a), 7);
        check("s31_cnt", int'(cnt_a), 1);

        // fallback keeps "00"
        cycle(1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        feed(0, 0, 2, 5);
        check("s32_cnt", int'(cnt_a), 1);

        cycle(1'b0, 1'b1, 0);
        feed(0, 0, 2, 7);
        check("s33_sum", int'(sum_a), 9);
        check("s33_cnt", int'(cnt_a), 0);

        // idle cycles between digits
        cycle(1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, pat[0][i]);
            cycle(1'b0, 1'b0, 5);
        end
        check("s34_cnt", int'(cnt_a), 1);

        cycle(1'b0, 1'b1, 0);
        feed(1, 2, 1, 2);
        cycle(1'b1, 1'b0, 1);
        cycle(1'b1, 1'b0, 2);
        check("s35_cnt_b", int'(cnt_b), OVL ? 2 : 1);

        // asynchronous reset mid-sequence
        cycle(1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 2);
        RST_n = 1'b0;
        #1;
        check("s36_rst_sum", int'(sum_a), 0);
        m_clear();
        #1 RST_n = 1'b1;
        cycle(1'b1, 1'b0, 5);
        check("s36_rst_sum5", int'(sum_a), 5);
        check("s36_rst_cnt",  int'(cnt_a), 0);

        // clr (with din_valid high) mid-sequence
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 2);
        cycle(1'b1, 1'b1, 5);
        cycle(1'b1, 1'b0, 5);
        check("s36_clr_sum5", int'(sum_a), 5);
        check("s36_clr_cnt",  int'(cnt_a), 0);

        // counter saturation on unit b
        cycle(1'b0, 1'b1, 0);
        for (int i = 0; i < 300; i++) feed(1, 2, 1, 2);
        check("sat_cnt_b", int'(cnt_b), 255);

        // randomised traffic
        cycle(1'b0, 1'b1, 0);
        for (int i = 0; i < 3000; i++) begin
            int sel = int'($urandom_range(0, 5));
            int d;
            case (sel)
                0: d = 0;
                1: d = 1;
                2: d = 2;
                3: d = 5;
                default: d = int'($urandom_range(0, 15));
            endcase
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0), d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
